// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller
// Time-multiplexed scan controller for a common-anode multi-digit
// seven-segment display. A slot counter divides each digit slot into a
// blanking phase, with all digits off, followed by a show phase, with one
// active-low enable driven. Host loads are held in a pending buffer and
// copied into the display buffer only at a frame boundary. This keeps every
// frame consistent.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   load         single-cycle strobe, captures value/dash_mask into pending
//   value        nibble per digit, digit 0 = value[3:0] (rightmost)
//   dash_mask    bit i = 1 shows a dash on digit i
//   lz_suppress  level, blank leading zero digits
//   digit_bits   nibble to the shared segment decoder
//   dash         dash flag to the shared segment decoder
//   digit_en     active-low digit enables, at most one bit low
//   load_ack     one-cycle pulse when a pending load is committed
module ssd_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dash_mask,
  input  logic                    lz_suppress,
  output logic [3:0]              digit_bits,
  output logic                    dash,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    load_ack
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_nxt;
  logic [IDX_W-1:0]        idx_q, idx_nxt;
  logic                    pend_q, pend_nxt;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_nxt;
  logic [NUM_DIGITS-1:0]   pend_dash_q, pend_dash_nxt;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_nxt;
  logic [NUM_DIGITS-1:0]   disp_dash_q, disp_dash_nxt;

  logic                    slot_end;
  logic                    frame_end;
  logic                    commit;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   supp;
  logic [3:0]              sel_bits;
  logic                    sel_dash;
  logic [NUM_DIGITS-1:0]   en_nxt;

  // Slot and frame sequencing, buffer handoff.
  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    cnt_nxt   = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_nxt   = idx_q;
    if (slot_end) begin
      idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    // At the boundary the old pending data commits first. A load sampled on
    // the same edge then refills pending for the next frame.
    commit        = frame_end && pend_q;
    disp_val_nxt  = commit ? pend_val_q  : disp_val_q;
    disp_dash_nxt = commit ? pend_dash_q : disp_dash_q;

    pend_nxt      = pend_q;
    pend_val_nxt  = pend_val_q;
    pend_dash_nxt = pend_dash_q;
    if (commit) begin
      pend_nxt = 1'b0;
    end
    if (load) begin
      pend_nxt      = 1'b1;
      pend_val_nxt  = value;
      pend_dash_nxt = dash_mask;
    end
  end

  // Leading-zero run, scanned from the most significant digit down. A dash
  // digit ends the run, so it and everything below it stay lit.
  always_comb begin
    zero_run = 1'b1;
    supp     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (disp_val_nxt[4*i +: 4] == 4'd0) & ~disp_dash_nxt[i];
      if (i > 0) begin
        supp[i] = lz_suppress & zero_run;
      end
    end
  end

  // Outputs are computed from next-state values so that the registered
  // outputs line up with the counter state they describe.
  always_comb begin
    sel_bits = 4'd0;
    sel_dash = 1'b0;
    en_nxt   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        sel_bits = disp_val_nxt[4*i +: 4];
        sel_dash = disp_dash_nxt[i];
        if ((cnt_nxt >= CNT_SHOW) && !supp[i]) begin
          en_nxt[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      pend_val_q  <= '0;
      pend_dash_q <= '0;
      disp_val_q  <= '0;
      disp_dash_q <= '0;
      digit_bits  <= 4'd0;
      dash        <= 1'b0;
      digit_en    <= '1;
      load_ack    <= 1'b0;
    end else begin
      cnt_q       <= cnt_nxt;
      idx_q       <= idx_nxt;
      pend_q      <= pend_nxt;
      pend_val_q  <= pend_val_nxt;
      pend_dash_q <= pend_dash_nxt;
      disp_val_q  <= disp_val_nxt;
      disp_dash_q <= disp_dash_nxt;
      // The decoder input changes only at slot start, ahead of the enable.
      if (cnt_nxt == '0) begin
        digit_bits <= sel_bits;
        dash       <= sel_dash;
      end
      digit_en    <= en_nxt;
      load_ack    <= commit;
    end
  end

endmodule

// File: tb/tb_ssd_scan_controller.sv
module tb_ssd_scan_controller;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dash_mask = 4'h0;
  logic        lz_suppress = 1'b0;
  logic [3:0]  digit_bits;
  logic        dash;
  logic [3:0]  digit_en;
  logic        load_ack;

  ssd_scan_controller #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value),
    .dash_mask(dash_mask), .lz_suppress(lz_suppress),
    .digit_bits(digit_bits), .dash(dash), .digit_en(digit_en),
    .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: slot position derives from the cycle count since reset.
  int          m_t = 0;
  bit          m_pend = 1'b0;
  logic [15:0] m_pv = 16'h0, m_dv = 16'h0;
  logic [3:0]  m_pd = 4'h0, m_dd = 4'h0;
  logic [3:0]  e_en = 4'hF, e_bits = 4'h0;
  logic        e_dash = 1'b0, e_ack = 1'b0;

  function automatic bit m_suppressed(input int d);
    if (!lz_suppress || d == 0) return 1'b0;
    for (int j = d; j < ND; j++) begin
      if (m_dv[j*4 +: 4] != 4'h0 || m_dd[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_pend = 1'b0; m_pv = '0; m_pd = '0; m_dv = '0; m_dd = '0;
      e_en = 4'hF; e_bits = 4'h0; e_dash = 1'b0; e_ack = 1'b0;
    end else begin
      int pos, dig;
      m_t++;
      e_ack = 1'b0;
      if ((m_t % FRAME) == 0 && m_pend) begin
        m_dv = m_pv; m_dd = m_pd; m_pend = 1'b0; e_ack = 1'b1;
      end
      if (load) begin
        m_pv = value; m_pd = dash_mask; m_pend = 1'b1;
      end
      pos = m_t % RD;
      dig = (m_t / RD) % ND;
      e_bits = m_dv[dig*4 +: 4];
      e_dash = m_dd[dig];
      e_en = 4'hF;
      if (pos >= BC && !m_suppressed(dig)) e_en[dig] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_en", 32'(digit_en), 32'(e_en));
      chk("model_bits", 32'(digit_bits), 32'(e_bits));
      chk("model_dash", 32'(dash), 32'(e_dash));
      chk("model_ack", 32'(load_ack), 32'(e_ack));
    end
  end

  task automatic wait_until(input int ph);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((m_t % FRAME) != ph && k < 2 * FRAME);
    if ((m_t % FRAME) != ph) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_phase: got %0d expected %0d", m_t % FRAME, ph);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dm);
    load = 1'b1; value = v; dash_mask = dm;
    @(negedge clk);
    load = 1'b0;
  endtask

  typedef struct { int n; logic [3:0] en; } scan_t;
  typedef struct { logic [15:0] v; logic [3:0] dm; logic lz; logic [3:0] en_mask; } sup_t;

  scan_t scan_tab[10];
  sup_t  sup_tab[6];
  logic [3:0] nib_tab [4];
  logic [3:0] ee;

  initial begin
    scan_tab[0] = '{1, 4'hF}; scan_tab[1] = '{6, 4'hE};
    scan_tab[2] = '{2, 4'hF}; scan_tab[3] = '{6, 4'hD};
    scan_tab[4] = '{2, 4'hF}; scan_tab[5] = '{6, 4'hB};
    scan_tab[6] = '{2, 4'hF}; scan_tab[7] = '{6, 4'h7};
    scan_tab[8] = '{2, 4'hF}; scan_tab[9] = '{6, 4'hE};

    sup_tab[0] = '{16'h0070, 4'b0000, 1'b1, 4'b0011};
    sup_tab[1] = '{16'h0070, 4'b1000, 1'b1, 4'b1111};
    sup_tab[2] = '{16'h0070, 4'b0000, 1'b0, 4'b1111};
    sup_tab[3] = '{16'h0000, 4'b0000, 1'b1, 4'b0001};
    sup_tab[4] = '{16'h1000, 4'b0000, 1'b1, 4'b1111};
    sup_tab[5] = '{16'h0000, 4'b0100, 1'b1, 4'b0111};

    nib_tab[0] = 4'h4; nib_tab[1] = 4'hA; nib_tab[2] = 4'h2; nib_tab[3] = 4'h1;

    // Reset values
    repeat (1) @(negedge clk);
    chk("rst_en", 32'(digit_en), 32'hF);
    chk("rst_bits", 32'(digit_bits), 32'h0);
    chk("rst_dash", 32'(dash), 32'h0);
    chk("rst_ack", 32'(load_ack), 32'h0);
    chk_on = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running scan pattern with an empty display
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < scan_tab[r].n; c++) begin
        @(negedge clk);
        chk("scan_en", 32'(digit_en), 32'(scan_tab[r].en));
        chk("scan_bits", 32'(digit_bits), 32'h0);
      end
    end

    // Mid-frame load during the digit-1 slot
    wait_until(11);
    do_load(16'h12A4, 4'h0);
    wait_until(FRAME - 1);
    chk("mid_before_ack", 32'(load_ack), 32'h0);
    chk("mid_before_bits", 32'(digit_bits), 32'h0);
    @(negedge clk);
    chk("mid_ack", 32'(load_ack), 32'h1);
    for (int d = 0; d < ND; d++) begin
      wait_until(d * RD + 3);
      chk("mid_bits", 32'(digit_bits), 32'(nib_tab[d]));
      if (d == 0) chk("mid_ack_low", 32'(load_ack), 32'h0);
    end

    // Two loads in one frame: the later one wins, one ack
    wait_until(5);
    do_load(16'h1111, 4'h0);
    wait_until(20);
    do_load(16'h2222, 4'h0);
    wait_until(0);
    chk("dbl_ack", 32'(load_ack), 32'h1);
    for (int d = 0; d < ND; d++) begin
      wait_until(d * RD + 4);
      chk("dbl_bits", 32'(digit_bits), 32'h2);
    end

    // Load on the boundary cycle while another load is pending
    wait_until(12);
    do_load(16'h0005, 4'h0);
    wait_until(FRAME - 1);
    do_load(16'h0006, 4'h0);
    chk("col_ack1", 32'(load_ack), 32'h1);
    chk("col_bits1", 32'(digit_bits), 32'h5);
    @(negedge clk);
    chk("col_ack_low", 32'(load_ack), 32'h0);
    wait_until(0);
    chk("col_ack2", 32'(load_ack), 32'h1);
    chk("col_bits2", 32'(digit_bits), 32'h6);

    // Leading-zero suppression table
    for (int r = 0; r < 6; r++) begin
      wait_until(10);
      lz_suppress = sup_tab[r].lz;
      do_load(sup_tab[r].v, sup_tab[r].dm);
      wait_until(0);
      chk("sup_ack", 32'(load_ack), 32'h1);
      for (int d = 0; d < ND; d++) begin
        wait_until(d * RD + 4);
        ee = 4'hF;
        if (sup_tab[r].en_mask[d]) ee[d] = 1'b0;
        chk("sup_en", 32'(digit_en), 32'(ee));
        chk("sup_bits", 32'(digit_bits), 32'(sup_tab[r].v[d*4 +: 4]));
        chk("sup_dash", 32'(dash), 32'(sup_tab[r].dm[d]));
      end
    end

    // Randomized loads and suppression toggling, checked by the model
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      load = ($urandom_range(0, 11) == 0);
      for (int n = 0; n < ND; n++) begin
        value[n*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      dash_mask = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      if ($urandom_range(0, 40) == 0) lz_suppress = ~lz_suppress;
    end
    @(negedge clk);
    load = 1'b0;

    // Asynchronous reset in the middle of a SHOW phase
    lz_suppress = 1'b0;
    wait_until(10);
    do_load(16'h9876, 4'h0);
    wait_until(4);
    chk("ar_pre_en", 32'(digit_en), 32'hE);
    do_load(16'h5555, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_en", 32'(digit_en), 32'hF);
    chk("ar_ack", 32'(load_ack), 32'h0);
    chk("ar_bits", 32'(digit_bits), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= FRAME + 2; c++) begin
      @(negedge clk);
      ee = 4'hF;
      if ((c % RD) >= BC) ee[(c / RD) % ND] = 1'b0;
      chk("ar_scan_en", 32'(digit_en), 32'(ee));
      chk("ar_scan_bits", 32'(digit_bits), 32'h0);
      chk("ar_scan_ack", 32'(load_ack), 32'h0);
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
